// File: rtl/bus_pkg.sv
// Shared constants for the internal bus arbiter: source indices, defaults and
// the conflict-counter update rule.
package bus_pkg;

  localparam int NSRC_DEFAULT = 32'd24;
  localparam logic [7:0] CNT_MAX = 8'hFF;

  localparam logic [4:0] SRC_R0     = 5'd0;
  localparam logic [4:0] SRC_R1     = 5'd1;
  localparam logic [4:0] SRC_R2     = 5'd2;
  localparam logic [4:0] SRC_R3     = 5'd3;
  localparam logic [4:0] SRC_R4     = 5'd4;
  localparam logic [4:0] SRC_R5     = 5'd5;
  localparam logic [4:0] SRC_R6     = 5'd6;
  localparam logic [4:0] SRC_R7     = 5'd7;
  localparam logic [4:0] SRC_R8     = 5'd8;
  localparam logic [4:0] SRC_R9     = 5'd9;
  localparam logic [4:0] SRC_R10    = 5'd10;
  localparam logic [4:0] SRC_R11    = 5'd11;
  localparam logic [4:0] SRC_R12    = 5'd12;
  localparam logic [4:0] SRC_R13    = 5'd13;
  localparam logic [4:0] SRC_R14    = 5'd14;
  localparam logic [4:0] SRC_R15    = 5'd15;
  localparam logic [4:0] SRC_HI     = 5'd16;
  localparam logic [4:0] SRC_LO     = 5'd17;
  localparam logic [4:0] SRC_ZHIGH  = 5'd18;
  localparam logic [4:0] SRC_ZLOW   = 5'd19;
  localparam logic [4:0] SRC_PC     = 5'd20;
  localparam logic [4:0] SRC_MDR    = 5'd21;
  localparam logic [4:0] SRC_INPORT = 5'd22;
  localparam logic [4:0] SRC_CSIGN  = 5'd23;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_DRIVE = 2'd1,
    ARB_BLOCK = 2'd2
  } arb_mode_e;

  // A conflict in the same cycle as a clear wins, so the new event is never lost.
  function automatic logic [7:0] conflict_cnt_next(input logic [7:0] cnt,
                                                   input logic       hit,
                                                   input logic       clr);
    logic [7:0] nxt;
    if (hit) begin
      if (clr) begin
        nxt = 8'd1;
      end else if (cnt == CNT_MAX) begin
        nxt = CNT_MAX;
      end else begin
        nxt = cnt + 8'd1;
      end
    end else if (clr) begin
      nxt = 8'd0;
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/prio_enc_cnt.sv
// Lowest-index priority encoder over the bus drive enables, with flags for
// "any enable" and "two or more enables".
module prio_enc_cnt
  import bus_pkg::*;
#(
  parameter int NSRC = NSRC_DEFAULT,
  parameter int SELW = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] en,
  output logic [SELW-1:0] idx,
  output logic            any,
  output logic            multi
);

  localparam logic [NSRC-1:0] ONE = {{(NSRC-1){1'b0}}, 1'b1};

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      idx = en[i] ? i[SELW-1:0] : idx;
    end
  end

  assign any   = |en;
  assign multi = |(en & (en - ONE));

endmodule

// File: rtl/bus_arbiter_reg.sv
// Registered internal-bus arbiter: one-hot source selection with optional
// output pipeline, idle hold, strict conflict blocking and conflict debug counter.
module bus_arbiter_reg
  import bus_pkg::*;
#(
  parameter int WIDTH = 32'd32,
  parameter int NSRC  = NSRC_DEFAULT,
  parameter int PIPE  = 32'd1,
  parameter int HOLD  = 32'd1,
  parameter int SELW  = $clog2(NSRC)
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       src_out,
  input  logic                  strict,
  input  logic                  conflict_clr,
  output logic [WIDTH-1:0]      bus_out,
  output logic                  bus_valid,
  output logic [SELW-1:0]       sel_idx,
  output logic                  conflict,
  output logic [7:0]            conflict_cnt
);

  logic [WIDTH-1:0] src_arr_s [NSRC];
  logic [SELW-1:0]  idx_s;
  logic             any_s;
  logic             multi_s;
  arb_mode_e        mode_s;
  logic [WIDTH-1:0] drive_s;
  logic             valid_s;
  logic [SELW-1:0]  sel_next_s;
  logic [WIDTH-1:0] last_s;
  logic [SELW-1:0]  sel_r;
  logic             conflict_r;
  logic [7:0]       cnt_r;

  for (genvar g = 0; g < NSRC; g++) begin : g_unpack
    assign src_arr_s[g] = src_data[g*WIDTH +: WIDTH];
  end

  prio_enc_cnt #(.NSRC(NSRC), .SELW(SELW)) u_prio (
    .en    (src_out),
    .idx   (idx_s),
    .any   (any_s),
    .multi (multi_s)
  );

  always_comb begin
    if (!any_s) begin
      mode_s = ARB_IDLE;
    end else if (multi_s && strict) begin
      mode_s = ARB_BLOCK;
    end else begin
      mode_s = ARB_DRIVE;
    end
  end

  // A blocked or idle cycle leaves the select index where it was.
  always_comb begin
    drive_s    = '0;
    valid_s    = 1'b0;
    sel_next_s = sel_r;
    case (mode_s)
      ARB_DRIVE: begin
        drive_s    = src_arr_s[idx_s];
        valid_s    = 1'b1;
        sel_next_s = idx_s;
      end
      ARB_BLOCK: drive_s = '0;
      ARB_IDLE:  drive_s = (HOLD != 32'sd0) ? last_s : '0;
      default:   drive_s = '0;
    endcase
  end

  if (HOLD != 32'sd0) begin : g_last
    logic [WIDTH-1:0] last_r;
    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
        last_r <= '0;
      end else if (valid_s) begin
        last_r <= drive_s;
      end else begin
        last_r <= last_r;
      end
    end
    assign last_s = last_r;
  end else begin : g_no_last
    assign last_s = '0;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sel_r      <= '0;
      conflict_r <= 1'b0;
      cnt_r      <= 8'd0;
    end else begin
      sel_r      <= sel_next_s;
      conflict_r <= multi_s | (conflict_r & ~conflict_clr);
      cnt_r      <= conflict_cnt_next(cnt_r, multi_s, conflict_clr);
    end
  end

  if (PIPE != 32'sd0) begin : g_pipe
    logic [WIDTH-1:0] bus_r;
    logic             valid_r;
    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
        bus_r   <= '0;
        valid_r <= 1'b0;
      end else begin
        bus_r   <= drive_s;
        valid_r <= valid_s;
      end
    end
    assign bus_out   = bus_r;
    assign bus_valid = valid_r;
    assign sel_idx   = sel_r;
  end else begin : g_comb
    // Reset still has to force the combinational outputs low.
    assign bus_out   = clr_n ? drive_s : '0;
    assign bus_valid = clr_n & valid_s;
    assign sel_idx   = clr_n ? sel_next_s : '0;
  end

  assign conflict     = conflict_r;
  assign conflict_cnt = cnt_r;

endmodule

// File: tb/tb_bus_arbiter_reg.sv
// Scoreboard bench for bus_arbiter_reg: default build, a HOLD=0 build sharing its
// stimulus, and a WIDTH=16/NSRC=2/PIPE=0 build.
module tb_bus_arbiter_reg;
  import bus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           clr_n;
  logic [767:0]   src_data;
  logic [23:0]    src_out;
  logic           strict;
  logic           conflict_clr;

  logic [31:0] bus_m, bus_h;
  logic        valid_m, valid_h, conf_m, conf_h;
  logic [4:0]  sel_m, sel_h;
  logic [7:0]  cnt_m, cnt_h;

  logic [31:0] s_data;
  logic [1:0]  s_out;
  logic [15:0] bus_s;
  logic        valid_s, conf_s;
  logic [0:0]  sel_s;
  logic [7:0]  cnt_s;

  bus_arbiter_reg u_main (
    .clk(clk), .clr_n(clr_n), .src_data(src_data), .src_out(src_out),
    .strict(strict), .conflict_clr(conflict_clr),
    .bus_out(bus_m), .bus_valid(valid_m), .sel_idx(sel_m),
    .conflict(conf_m), .conflict_cnt(cnt_m));

  bus_arbiter_reg #(.HOLD(0)) u_hold0 (
    .clk(clk), .clr_n(clr_n), .src_data(src_data), .src_out(src_out),
    .strict(strict), .conflict_clr(conflict_clr),
    .bus_out(bus_h), .bus_valid(valid_h), .sel_idx(sel_h),
    .conflict(conf_h), .conflict_cnt(cnt_h));

  bus_arbiter_reg #(.WIDTH(16), .NSRC(2), .PIPE(0), .HOLD(1)) u_small (
    .clk(clk), .clr_n(clr_n), .src_data(s_data), .src_out(s_out),
    .strict(1'b0), .conflict_clr(1'b0),
    .bus_out(bus_s), .bus_valid(valid_s), .sel_idx(sel_s),
    .conflict(conf_s), .conflict_cnt(cnt_s));

  typedef struct {
    int          due;
    int          dut;
    string       name;
    logic [31:0] bus;
    logic        valid;
    logic [4:0]  sel;
    logic        conf;
    logic [7:0]  cnt;
    logic [4:0]  mask;
  } exp_t;

  localparam logic [4:0] M_ALL = 5'b11111;
  localparam logic [4:0] M_BVS = 5'b11100;
  localparam logic [4:0] M_CNT = 5'b00001;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_at(input int due, input int dut, input string name, input logic [4:0] mask,
                           input logic [31:0] bus, input logic valid, input logic [4:0] sel,
                           input logic conf, input logic [7:0] cnt);
    sb.push_back('{due, dut, name, bus, valid, sel, conf, cnt, mask});
  endtask

  task automatic cycle_in();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [31:0] v);
    src_data[i*32 +: 32] = v;
  endtask

  // Monitor: compare every expectation that falls due at this falling edge.
  always @(negedge clk) begin : mon
    exp_t        e;
    logic [31:0] ab;
    logic        av, ac;
    logic [4:0]  as;
    logic [7:0]  an;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      case (e.dut)
        0:       begin ab = bus_m; av = valid_m; as = sel_m; ac = conf_m; an = cnt_m; end
        1:       begin ab = bus_h; av = valid_h; as = sel_h; ac = conf_h; an = cnt_h; end
        default: begin ab = {16'h0, bus_s}; av = valid_s; as = {4'b0, sel_s}; ac = conf_s; an = cnt_s; end
      endcase
      if (e.due < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s missed due=%0d now=%0d", e.name, e.due, cyc);
      end else begin
        if (e.mask[4]) chk({e.name, ".bus"},   ab, e.bus);
        if (e.mask[3]) chk({e.name, ".valid"}, {31'b0, av}, {31'b0, e.valid});
        if (e.mask[2]) chk({e.name, ".sel"},   {27'b0, as}, {27'b0, e.sel});
        if (e.mask[1]) chk({e.name, ".conf"},  {31'b0, ac}, {31'b0, e.conf});
        if (e.mask[0]) chk({e.name, ".cnt"},   {24'b0, an}, {24'b0, e.cnt});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n = 1'b0; src_data = '0; src_out = '0; strict = 1'b0; conflict_clr = 1'b0;
    s_data = '0; s_out = '0;
    repeat (2) @(posedge clk);
    #1;
    expect_at(cyc, 0, "reset_m", M_ALL, 32'h0, 1'b0, 5'd0, 1'b0, 8'd0);
    expect_at(cyc, 1, "reset_h", M_ALL, 32'h0, 1'b0, 5'd0, 1'b0, 8'd0);

    cycle_in();
    clr_n = 1'b1;
    set_src(SRC_PC, 32'h0000_0040);
    src_out = 24'd1 << SRC_PC;
    expect_at(cyc + 1, 0, "onehot_pc", M_ALL, 32'h40, 1'b1, 5'd20, 1'b0, 8'd0);
    expect_at(cyc + 1, 1, "onehot_pc_h0", M_ALL, 32'h40, 1'b1, 5'd20, 1'b0, 8'd0);

    cycle_in();
    set_src(SRC_MDR, 32'hDEAD_BEEF);
    src_out = 24'd1 << SRC_MDR;
    expect_at(cyc + 1, 0, "mdr", M_ALL, 32'hDEAD_BEEF, 1'b1, 5'd21, 1'b0, 8'd0);
    expect_at(cyc + 1, 1, "mdr_h0", M_ALL, 32'hDEAD_BEEF, 1'b1, 5'd21, 1'b0, 8'd0);

    for (int i = 0; i < 2; i++) begin
      cycle_in();
      src_out = '0;
      expect_at(cyc + 1, 0, "idle_hold", M_ALL, 32'hDEAD_BEEF, 1'b0, 5'd21, 1'b0, 8'd0);
      expect_at(cyc + 1, 1, "idle_zero", M_ALL, 32'h0, 1'b0, 5'd21, 1'b0, 8'd0);
    end

    cycle_in();
    set_src(SRC_R3, 32'd5);
    set_src(SRC_HI, 32'd9);
    src_out = (24'd1 << SRC_R3) | (24'd1 << SRC_HI);
    expect_at(cyc + 1, 0, "conf_prio", M_ALL, 32'd5, 1'b1, 5'd3, 1'b1, 8'd1);

    cycle_in();
    strict = 1'b1;
    expect_at(cyc + 1, 0, "conf_strict", M_ALL, 32'd0, 1'b0, 5'd3, 1'b1, 8'd2);
    expect_at(cyc + 1, 1, "conf_strict_h0", M_ALL, 32'd0, 1'b0, 5'd3, 1'b1, 8'd2);

    cycle_in();
    strict = 1'b0;
    // Count after step i of this burst is i+3 until it saturates.
    for (int i = 0; i < 300; i++) begin
      if (i > 0) cycle_in();
      if (i == 251) expect_at(cyc + 1, 0, "sat_254", M_CNT, 32'd0, 1'b0, 5'd0, 1'b0, 8'd254);
      if (i == 299) expect_at(cyc + 1, 0, "sat_255", M_ALL, 32'd5, 1'b1, 5'd3, 1'b1, 8'd255);
    end

    cycle_in();
    set_src(SRC_R0, 32'd7);
    src_out = 24'd1;
    conflict_clr = 1'b1;
    expect_at(cyc + 1, 0, "clr_only", M_ALL, 32'd7, 1'b1, 5'd0, 1'b0, 8'd0);

    cycle_in();
    src_out = (24'd1 << SRC_R3) | (24'd1 << SRC_HI);
    expect_at(cyc + 1, 0, "clr_with_conf", M_ALL, 32'd5, 1'b1, 5'd3, 1'b1, 8'd1);

    cycle_in();
    conflict_clr = 1'b0;
    set_src(SRC_R1, 32'h1234);
    src_out = 24'd1 << SRC_R1;
    expect_at(cyc + 1, 0, "pre_reset", M_ALL, 32'h1234, 1'b1, 5'd1, 1'b1, 8'd1);

    cycle_in();
    @(negedge clk);
    #1;
    clr_n = 1'b0;
    src_out = '0;
    #1;
    chk("mid_reset.bus", bus_m, 32'h0);
    chk("mid_reset.valid", {31'b0, valid_m}, 32'd0);
    chk("mid_reset.sel", {27'b0, sel_m}, 32'd0);
    chk("mid_reset.conf", {31'b0, conf_m}, 32'd0);
    chk("mid_reset.cnt", {24'b0, cnt_m}, 32'd0);
    expect_at(cyc + 1, 0, "in_reset", M_ALL, 32'h0, 1'b0, 5'd0, 1'b0, 8'd0);

    cycle_in();
    clr_n = 1'b1;
    expect_at(cyc + 1, 0, "post_reset", M_ALL, 32'h0, 1'b0, 5'd0, 1'b0, 8'd0);
    cycle_in();
    expect_at(cyc + 1, 0, "post_reset2", M_ALL, 32'h0, 1'b0, 5'd0, 1'b0, 8'd0);

    // Combinational build: outputs checked in the same cycle the inputs change.
    cycle_in();
    s_data = {16'hBEEF, 16'h1111};
    s_out = 2'b10;
    expect_at(cyc, 2, "s_src1", M_BVS, 32'hBEEF, 1'b1, 5'd1, 1'b0, 8'd0);
    cycle_in();
    s_out = 2'b01;
    expect_at(cyc, 2, "s_src0", M_BVS, 32'h1111, 1'b1, 5'd0, 1'b0, 8'd0);
    cycle_in();
    s_out = 2'b00;
    expect_at(cyc, 2, "s_hold", M_ALL, 32'h1111, 1'b0, 5'd0, 1'b0, 8'd0);
    cycle_in();
    s_data = {16'h2222, 16'h3333};
    s_out = 2'b11;
    expect_at(cyc, 2, "s_conf", M_BVS, 32'h3333, 1'b1, 5'd0, 1'b0, 8'd0);
    cycle_in();
    s_out = 2'b00;
    expect_at(cyc, 2, "s_after_conf", M_ALL, 32'h3333, 1'b0, 5'd0, 1'b1, 8'd1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_reg.md
# bus_arbiter_reg

Parametrised, registered successor to the CPU datapath bus multiplexer. It selects one of `NSRC` `WIDTH`-bit sources onto the shared internal bus, driven by one-hot `*out` enables from the control unit. Beyond plain selection it adds:
- an optional output pipeline register;
- a hold-last-value mode for idle cycles;
- a strict mode that blocks the bus on multi-driver conflicts;
- sticky conflict detection with a saturating event counter for debug.

## Interface
Parameters:
- `WIDTH`, 32: bus and source data width.
- `NSRC`, 24: number of bus sources; legal range 2–32.
- `PIPE`, 1: 1 = `bus_out` is registered (1-cycle latency); 0 = `bus_out` is combinational from the inputs.
- `HOLD`, 1: 1 = an idle bus keeps its last driven value; 0 = an idle bus drives zero.
- `SELW`, `$clog2(NSRC)`: width of the select index; derived, do not override.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `clr_n`  in  1  reset, asynchronous, active-low.
- `src_data`  in  `NSRC*WIDTH`  packed sources; source i occupies bits `[i*WIDTH +: WIDTH]`.
- `src_out`  in  `NSRC`  per-source drive enables, expected one-hot or zero.
- `strict`  in  1  1 = a conflict blocks the bus; 0 = lowest-index priority wins.
- `conflict_clr`  in  1  synchronous clear of `conflict` and `conflict_cnt`.
- `bus_out`  out  `WIDTH`  bus value.
- `bus_valid`  out  1  a source legally drove `bus_out` (same latency as `bus_out`).
- `sel_idx`  out  `SELW`  index of the selected source (same latency as `bus_out`).
- `conflict`  out  1  sticky flag: two or more enables were seen active in one cycle.
- `conflict_cnt`  out  8  count of conflict cycles, saturating at 255.

## Operation
- **Selection:** each cycle, `sel` is the lowest index i with `src_out[i]=1`, and `n` is the number of enables set.
- **n=1:** drive source `sel`; `valid=1`.
- **n≥2, `strict=0`:** drive source `sel` (lowest index wins); `valid=1`; counts as a conflict.
- **n≥2, `strict=1`:** drive 0; `valid=0`; `sel_idx` keeps its previous value; counts as a conflict.
- **n=0 (idle):** `valid=0`; `sel_idx` holds.
  - `HOLD=1`: drive the `last` register.
  - `HOLD=0`: drive 0.
- **`last` register:** loads the driven value on every valid cycle. It exists and is used only when `HOLD=1`.
- **Conflict cycles:** set `conflict`; `conflict_cnt` increments, saturating at 255 (it stays at 255).
- **`conflict_clr`:** `conflict_clr=1` with no conflict in the same cycle gives `conflict=0` and `cnt=0`. `conflict_clr=1` together with a conflict gives `conflict=1` and `cnt=1` (the new event is kept).
- **Reset values:** asserting `clr_n` at any time forces, asynchronously: `bus_out=0`, `bus_valid=0`, `sel_idx=0`, `conflict=0`, `conflict_cnt=0`, `last=0`. The first post-reset edge behaves as a normal cycle.
- **Source indices 0–23 are fixed:** R0–R15 = 0–15, HI = 16, LO = 17, Zhigh = 18, Zlow = 19, PC = 20, MDR = 21, InPort = 22, C_sign_extended = 23.

## Timing
- **`PIPE=1`:** enables and data sampled at edge k appear on `bus_out`, `bus_valid` and `sel_idx` after edge k, i.e. 1-cycle latency. Consumers latch them at edge k+1.
- **`PIPE=0`:** `bus_out` and `bus_valid` are combinational from the current inputs plus the `last` and `sel_idx` registers. There are no flops on the data path except `last`.
- **Conflict and counter updates:** always registered, landing 1 cycle after the conflicting cycle in both `PIPE` modes.
- **Back-to-back source changes:** fully supported every cycle, with no bubble.

## Structure
- **Shared package `bus_pkg`:**
  - the source index constants `SRC_R0` … `SRC_CSIGN` (values 0–23);
  - `NSRC_DEFAULT = 24`;
  - `CNT_MAX = 8'hFF`.
- **Sub-module `prio_enc_cnt`:** combinational; input `NSRC` enables; outputs the lowest-set index, an `any` flag and a `multi` flag (n≥2). The top level instantiates it once and holds all state.

## Test plan
- **One-hot selection:** reset; `src_out = 1<<20` with PC source = `32'h0000_0040`. Required after 1 edge: `bus_out = 32'h40`, `bus_valid = 1`, `sel_idx = 20`.
- **Idle hold:** `HOLD=1`, drive MDR = `32'hDEAD_BEEF` for one cycle, then `src_out = 0`. Required: `bus_out` stays `32'hDEADBEEF` with `bus_valid = 0`. With `HOLD=0` the same stimulus must give `bus_out = 0`.
- **Conflict in both modes:** `src_out` bits 3 and 16, R3 = 5, HI = 9.
  - `strict=0`: `bus_out = 5`, `sel_idx = 3`, `conflict = 1`, `cnt = 1`.
  - `strict=1`: `bus_out = 0`, `bus_valid = 0`, `sel_idx` unchanged, `cnt = 2`.
- **Counter saturation and clear:** 300 consecutive conflict cycles give `cnt = 255`. Then `conflict_clr` with no conflict gives `cnt = 0`, `conflict = 0`. Then `conflict_clr` together with a conflict gives `cnt = 1`, `conflict = 1`.
- **Reset mid-operation:** pull `clr_n` low between edges while `bus_out = 32'h1234`. Required immediately: all outputs 0. After release with `src_out = 0` and `HOLD=1`: `bus_out` stays 0.
- **Parametric corners:** build `WIDTH=16`, `NSRC=2`, `PIPE=0`. Required: source 1 selected combinationally in the same cycle; packing places source 1 at bits `[31:16]`.
